// File: rtl/lct_l1a_matcher.sv
// Per-channel LCT history with L1A coincidence window, event numbering
// and a first-word fall-through event record FIFO.
module lct_l1a_matcher #(
    parameter int NCH        = 8,
    parameter int HIST_DEPTH = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NCH-1:0]      lct,
    input  logic                l1a,
    input  logic [7:0]          lct_l1a_dly,
    input  logic [2:0]          match_win,
    output logic [NCH-1:0]      l1a_match,
    output logic                l1a_match_vld,
    output logic [23+NCH:0]     evt_data,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [23:0]         l1a_num,
    output logic [15:0]         nomatch_cnt,
    output logic                evt_ovfl
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [8:0] HMAX = 9'(HIST_DEPTH);

    logic [HIST_DEPTH-1:0] hist [NCH];
    logic [8:0]            lo, hi, sum;
    logic [HIST_DEPTH:0]   win;
    logic [NCH-1:0]        match;
    logic                  acc;
    logic [23:0]           l1a_num_nxt;

    logic [23+NCH:0]       mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  full, pop, push_ok, drop;

    assign acc         = en & l1a;
    assign l1a_num_nxt = l1a_num + 24'd1;

    // Window bounds in lag units; lag 0 is the live lct input, lag n>=1 is hist[n-1].
    always_comb begin
        sum = {1'b0, lct_l1a_dly} + {6'b0, match_win};
        lo  = (lct_l1a_dly >= {5'b0, match_win}) ? {1'b0, lct_l1a_dly - {5'b0, match_win}} : '0;
        hi  = (sum > HMAX) ? HMAX : sum;
        win = '0;
        for (int unsigned n = 0; n <= HIST_DEPTH; n++) begin
            win[n] = (9'(n) >= lo) && (9'(n) <= hi);
        end
    end

    always_comb begin
        match = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            match[ch] = |({hist[ch], lct[ch]} & win);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                hist[ch] <= '0;
            end
        end else if (en) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                hist[ch] <= {hist[ch][HIST_DEPTH-2:0], lct[ch]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1a_match     <= '0;
            l1a_match_vld <= 1'b0;
            l1a_num       <= '0;
            nomatch_cnt   <= '0;
        end else begin
            l1a_match_vld <= acc;
            if (acc) begin
                l1a_match <= match;
                l1a_num   <= l1a_num_nxt;
                if (match == '0 && nomatch_cnt != '1) begin
                    nomatch_cnt <= nomatch_cnt + 16'd1;
                end
            end
        end
    end

    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign evt_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = evt_valid & evt_ready;
    assign push_ok   = acc & (~full | pop);
    assign drop      = acc & full & ~pop;
    assign evt_data  = evt_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {l1a_num_nxt, match};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            evt_ovfl <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (drop)    evt_ovfl <= 1'b1;
        end
    end

endmodule

// File: doc/lct_l1a_matcher.md
Name: lct_l1a_matcher

Overview:
Per-DCFEB LCT/L1A coincidence stage. It sits directly downstream of the LCT/L1A stimulus source in the ODMB simulation, and of the trigger inputs in hardware. It keeps a per-channel LCT history and, on each L1A, flags which channels had an LCT within a programmable delay window. It then queues an event record of the L1A number and the match mask for the readout controller.

Parameters:
NCH, 8, number of LCT/DCFEB channels
HIST_DEPTH, 256, LCT history length in clock cycles (index 0..HIST_DEPTH-1)
FIFO_DEPTH, 16, event record FIFO entries (power of 2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; 0 freezes history and ignores l1a
lct  in  NCH  per-channel LCT strobe, sampled each edge
l1a  in  1  L1A strobe, sampled each edge
lct_l1a_dly  in  8  nominal LCT-to-L1A delay D, in cycles
match_win  in  3  window half-width W, in cycles
l1a_match  out  NCH  match mask for the most recent L1A
l1a_match_vld  out  1  one-cycle pulse when l1a_match updates
evt_data  out  24+NCH  FIFO head: {l1a_num[23:0], match[NCH-1:0]}
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer pop; a pop occurs when evt_valid and evt_ready are both 1
l1a_num  out  24  count of accepted L1As
nomatch_cnt  out  16  accepted L1As with an all-zero mask (saturating)
evt_ovfl  out  1  sticky: an event was dropped on a full FIFO

Behaviour:
- Reset (rst_n=0, async): clears the history, FIFO pointers, l1a_match, l1a_match_vld, l1a_num, nomatch_cnt and evt_ovfl. evt_valid=0. evt_data reads 0 when empty.
- History:
  - Each edge with en=1, channel ch shifts: hist[ch][k] <= hist[ch][k-1], hist[ch][0] <= lct[ch].
  - hist[ch][n] before the edge holds the LCT sampled n+1 edges ago.
  - With en=0 the history holds and l1a is ignored.
- Lag: an LCT sampled at edge t-n and an L1A sampled at edge t have lag n. n=0 is the same edge, using the lct input directly.
- Window:
  - lo = max(0, D-W); hi = min(HIST_DEPTH, D+W). Computed in 9-bit unsigned; never wraps.
  - match[ch] = OR of the LCT at lags lo..hi inclusive. Lag n≥1 maps to hist[ch][n-1].
  - D and W are used combinationally every cycle. A change takes effect on the next L1A; no flush.
- Accepted L1A: en=1 and l1a=1 at edge t. At edge t:
  - l1a_match <= match; l1a_match_vld <= 1 (latency 1, visible after edge t).
  - l1a_num <= l1a_num+1, wrapping FFFFFF->000000. The first L1A after reset is numbered 1.
  - If match==0, nomatch_cnt increments and saturates at FFFF.
  - A record {new l1a_num, match} is pushed to the FIFO.
- l1a_match_vld is 0 on any edge without an accepted L1A. l1a_match holds its last value.
- Back-to-back L1As on consecutive edges are each evaluated independently, and each gets its own record.
- FIFO:
  - First-word fall-through: evt_data is the head whenever evt_valid=1.
  - Push when full with no pop: the record is dropped and evt_ovfl <= 1. l1a_num and nomatch_cnt still update.
  - Push and pop on the same edge while full: both occur, no drop, occupancy unchanged.
  - Push and pop on the same edge while empty: the push is stored. The pop is ignored because evt_valid was 0.
  - evt_ovfl clears only on reset.
- en=0 mid-run: the FIFO still pops, and the outputs hold their values.

Test Plan:
1. Exact match: D=5, W=0; lct=8'h01 at edge 100, l1a at edge 105. Required: l1a_match=8'h01, vld pulse after edge 105, evt_data={24'h000001, 8'h01}, nomatch_cnt=0.
2. Window edges: D=10, W=2; LCTs on ch1 at lag 7, ch2 at lag 8, ch3 at lag 12, ch4 at lag 13. Required: mask=8'h0C (ch2, ch3 only). With D=1, W=3, an lct and l1a on the same edge match (lo clips to 0).
3. No match and saturation: 65540 L1As with no LCTs. Required: nomatch_cnt=FFFF, l1a_num=24'h010004, every mask 0.
4. FIFO overflow: evt_ready=0 and 17 L1As. Required: 16 records numbered 1..16, evt_ovfl=1, l1a_num=17. Then assert evt_ready together with L1A 18 while full. Required: 1 popped, 18 stored, no further drop.
5. Enable/reset: lct at edge 50, en=0 for edges 51-60, D=5, l1a at edge 65 with en=1. Required: match (history frozen, lag counts enabled edges only). Assert rst_n low mid-burst. Required: all outputs 0 asynchronously, and the next L1A is numbered 1.
6. l1a_num wrap: preload via 16777215 L1As (or force), then one more L1A. Required: l1a_num=000000 and the record carries 24'h000000.
